// File: rtl/stack_ctrl_if.sv
// Debug port of stack_ctrl: level request with op/data, one-cycle ack with result.
// The requester holds dbg_req, dbg_op and dbg_wd stable until dbg_ack.
interface stack_ctrl_if #(
    parameter int WIDTH = 18
);
    logic             dbg_req;
    logic [1:0]       dbg_op;
    logic [WIDTH-1:0] dbg_wd;
    logic             dbg_ack;
    logic [WIDTH-1:0] dbg_rd;

    modport master (output dbg_req, dbg_op, dbg_wd, input  dbg_ack, dbg_rd);
    modport slave  (input  dbg_req, dbg_op, dbg_wd, output dbg_ack, dbg_rd);
endinterface

// File: rtl/stack_ctrl.sv
// Stack controller: passes CPU stack ops through, tracks depth and sticky
// overflow/underflow, and arbitrates a debug port that stalls the CPU.
module stack_ctrl #(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 16,
    localparam int CAP   = DEPTH + 1,
    localparam int DW    = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_hold,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_delta,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic             cpu_stall,
    output logic             stk_hold,
    output logic             stk_we,
    output logic [1:0]       stk_delta,
    output logic [WIDTH-1:0] stk_wd,
    input  logic [WIDTH-1:0] stk_rd,
    stack_ctrl_if.slave      dbg,
    output logic [DW-1:0]    depth,
    output logic             ovf,
    output logic             unf,
    input  logic             err_clr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic [DW-1:0] CAP_D = DW'(CAP);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             ack_q;
    logic [WIDTH-1:0] rd_q;
    logic             push_ev;
    logic             pop_ev;
    logic             ovf_set;
    logic             unf_set;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dbg.dbg_req) state_nxt = S_STALL;
            S_STALL: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        stk_hold  = cpu_hold;
        stk_we    = cpu_we;
        stk_delta = cpu_delta;
        stk_wd    = cpu_wd;
        case (state)
            S_STALL, S_ACK: begin
                stk_hold  = 1'b1;
                stk_we    = 1'b0;
                stk_delta = 2'b00;
            end
            S_EXEC: begin
                stk_hold = 1'b0;
                stk_wd   = dbg.dbg_wd;
                case (dbg.dbg_op)
                    2'b01: begin
                        stk_we    = 1'b1;
                        stk_delta = 2'b01;
                    end
                    2'b10: begin
                        stk_we    = 1'b0;
                        stk_delta = 2'b10;
                    end
                    default: begin
                        stk_we    = 1'b0;
                        stk_delta = 2'b00;
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Depth/flag events follow what actually reaches the stack; delta 11 is a pop.
    assign push_ev = !stk_hold && (stk_delta == 2'b01);
    assign pop_ev  = !stk_hold && stk_delta[1];
    assign ovf_set = push_ev && (depth == CAP_D);
    assign unf_set = pop_ev && (depth == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cpu_stall <= 1'b0;
            ack_q     <= 1'b0;
            rd_q      <= '0;
            depth     <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_stall <= (state_nxt != S_IDLE);
            ack_q     <= (state == S_EXEC);

            if (state == S_EXEC)
                rd_q <= (dbg.dbg_op == 2'b01) ? dbg.dbg_wd : stk_rd;

            if (push_ev && (depth != CAP_D))
                depth <= depth + 1'b1;
            else if (pop_ev && (depth != '0))
                depth <= depth - 1'b1;

            // A set on the same edge as err_clr wins.
            ovf <= ovf_set | (ovf & ~err_clr);
            unf <= unf_set | (unf & ~err_clr);
        end
    end

    assign dbg.dbg_ack = ack_q;
    assign dbg.dbg_rd  = rd_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl with a behavioural shift-register stack
// behind it and a scoreboard of expected debug results.
module tb_stack_ctrl;

    localparam int WIDTH = 18;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cpu_hold;
    logic             cpu_we;
    logic [1:0]       cpu_delta;
    logic [WIDTH-1:0] cpu_wd;
    logic             cpu_stall;
    logic             stk_hold;
    logic             stk_we;
    logic [1:0]       stk_delta;
    logic [WIDTH-1:0] stk_wd;
    logic [WIDTH-1:0] stk_rd;
    logic [4:0]       depth;
    logic             ovf;
    logic             unf;
    logic             err_clr;

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] sb[$];

    stack_ctrl_if #(.WIDTH(WIDTH)) dbg ();

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_hold  (cpu_hold),
        .cpu_we    (cpu_we),
        .cpu_delta (cpu_delta),
        .cpu_wd    (cpu_wd),
        .cpu_stall (cpu_stall),
        .stk_hold  (stk_hold),
        .stk_we    (stk_we),
        .stk_delta (stk_delta),
        .stk_wd    (stk_wd),
        .stk_rd    (stk_rd),
        .dbg       (dbg),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Behavioural stack: head plus DEPTH tail cells.
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail [DEPTH];
    assign stk_rd = head;

    initial begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) tail[i] = '0;
    end

    always @(posedge clk) begin
        if (!stk_hold) begin
            if (stk_delta == 2'b01) begin
                for (int i = DEPTH - 1; i > 0; i--) tail[i] <= tail[i-1];
                tail[0] <= head;
                if (stk_we) head <= stk_wd;
            end else if (stk_delta[1]) begin
                head <= tail[0];
                for (int i = 0; i < DEPTH - 1; i++) tail[i] <= tail[i+1];
            end else if (stk_we) begin
                head <= stk_wd;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_clear();
        cpu_hold  = 1'b0;
        cpu_we    = 1'b0;
        cpu_delta = 2'b00;
        cpu_wd    = '0;
    endtask

    task automatic cpu_step(input logic h, input logic we, input logic [1:0] d,
                            input logic [WIDTH-1:0] wd);
        cpu_hold  = h;
        cpu_we    = we;
        cpu_delta = d;
        cpu_wd    = wd;
        @(posedge clk); #1;
        cpu_clear();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One debug transaction; noise drives a CPU push while the CPU is stalled.
    task automatic dbg_txn(input logic [1:0] op, input logic [WIDTH-1:0] wd,
                           input logic [WIDTH-1:0] exp_rd, input bit noise);
        bit got = 1'b0;
        sb.push_back(exp_rd);
        dbg.dbg_req = 1'b1;
        dbg.dbg_op  = op;
        dbg.dbg_wd  = wd;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (k == 0 && noise) begin
                cpu_we    = 1'b1;
                cpu_delta = 2'b01;
                cpu_wd    = 18'h12345;
            end
            if (k <= 2) check($sformatf("stall_k%0d", k), cpu_stall, 1);
            if (dbg.dbg_ack) begin
                got = 1'b1;
                check("ack_latency", k, 2);
                check("dbg_rd", dbg.dbg_rd, sb.pop_front());
                dbg.dbg_req = 1'b0;
                cpu_clear();
            end
        end
        check("ack_seen", got, 1);
        if (!got) begin
            dbg.dbg_req = 1'b0;
            cpu_clear();
            void'(sb.pop_front());
        end
        @(posedge clk); #1;
        check("stall_drop", cpu_stall, 0);
        check("ack_pulse", dbg.dbg_ack, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        err_clr     = 1'b0;
        dbg.dbg_req = 1'b0;
        dbg.dbg_op  = 2'b00;
        dbg.dbg_wd  = '0;
        cpu_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", cpu_stall, 0);
        check("rst_ack", dbg.dbg_ack, 0);
        check("rst_rd", dbg.dbg_rd, 0);
        check("rst_depth", depth, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);
        rst_n = 1'b1;

        // Basic CPU traffic
        cpu_step(0, 1, 2'b01, 18'h00001);
        cpu_step(0, 1, 2'b01, 18'h00002);
        cpu_step(0, 1, 2'b01, 18'h00003);
        check("push3_depth", depth, 3);
        check("push3_top", stk_rd, 18'h00003);
        check("push3_ovf", ovf, 0);
        check("push3_unf", unf, 0);
        cpu_step(0, 0, 2'b10, '0);
        check("pop_depth", depth, 2);
        check("pop_top", stk_rd, 18'h00002);

        // Debug pop, push (with CPU noise), read
        dbg_txn(2'b10, '0, 18'h00002, 1'b0);
        check("dpop_depth", depth, 1);
        check("dpop_top", stk_rd, 18'h00001);
        dbg_txn(2'b01, 18'h3FFFF, 18'h3FFFF, 1'b1);
        check("dpush_depth", depth, 2);
        check("dpush_top", stk_rd, 18'h3FFFF);
        dbg_txn(2'b11, 18'h00abc, 18'h3FFFF, 1'b0);
        check("dread_depth", depth, 2);
        check("dread_top", stk_rd, 18'h3FFFF);

        // Overflow and error clear
        reset_pulse();
        for (int i = 1; i <= 17; i++) cpu_step(0, 1, 2'b01, WIDTH'(i));
        check("full_depth", depth, 17);
        check("full_ovf", ovf, 0);
        cpu_step(0, 1, 2'b01, 18'd18);
        check("ovf_depth", depth, 17);
        check("ovf_set", ovf, 1);
        check("ovf_top", stk_rd, 18'd18);
        err_clr = 1'b1;
        cpu_step(0, 0, 2'b00, '0);
        err_clr = 1'b0;
        check("ovf_clr", ovf, 0);
        err_clr = 1'b1;
        cpu_step(0, 1, 2'b01, 18'd19);
        err_clr = 1'b0;
        check("ovf_set_wins", ovf, 1);
        check("ovf_depth2", depth, 17);

        // Underflow, write-only, hold
        reset_pulse();
        cpu_step(0, 0, 2'b10, '0);
        check("unf_depth", depth, 0);
        check("unf_set", unf, 1);
        cpu_step(0, 1, 2'b00, 18'h00055);
        check("we_depth", depth, 0);
        check("we_top", stk_rd, 18'h00055);
        cpu_step(1, 1, 2'b01, 18'h00077);
        check("hold_depth", depth, 0);
        cpu_step(0, 0, 2'b11, '0);
        check("d11_unf_depth", depth, 0);
        err_clr = 1'b1;
        cpu_step(0, 0, 2'b00, '0);
        err_clr = 1'b0;
        check("unf_clr", unf, 0);

        // Reset during EXEC aborts the transaction
        cpu_step(0, 1, 2'b01, 18'h00011);
        cpu_step(0, 1, 2'b01, 18'h00022);
        check("pre_abort_depth", depth, 2);
        dbg.dbg_req = 1'b1;
        dbg.dbg_op  = 2'b01;
        dbg.dbg_wd  = 18'h00033;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("exec_we", stk_we, 1);
        rst_n       = 1'b0;
        dbg.dbg_req = 1'b0;
        #1;
        check("abort_stall", cpu_stall, 0);
        check("abort_ack", dbg.dbg_ack, 0);
        check("abort_depth", depth, 0);
        check("abort_hold", stk_hold, 0);
        check("abort_we", stk_we, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("abort_noack%0d", i), dbg.dbg_ack, 0);
        end
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
